// File: rtl/i2c_apb_sequencer_if.sv
// i2c_apb_sequencer_if: APB bus between the sequencer (master) and the I2C core (slave).
// Signals: PSEL, PENABLE, PWRITE, PADDR, PWDATA driven by the master; PRDATA, PREADY by the slave.
interface i2c_apb_sequencer_if;
    logic        PSEL;
    logic        PENABLE;
    logic        PWRITE;
    logic [31:0] PADDR;
    logic [31:0] PWDATA;
    logic [31:0] PRDATA;
    logic        PREADY;
    modport master (output PSEL, PENABLE, PWRITE, PADDR, PWDATA, input PRDATA, PREADY);
    modport slave  (input PSEL, PENABLE, PWRITE, PADDR, PWDATA, output PRDATA, PREADY);
endinterface

// File: rtl/i2c_apb_sequencer.sv
// i2c_apb_sequencer: initialises an I2C master core over APB, then runs single-register I2C writes/reads.
// Ports: PCLK clock, PRESETn async active-low reset; req_valid/req_ready/req_write/req_dev/req_reg/req_wdata
//        request; rsp_valid/rsp_rdata/rsp_status completion; busy; apb master modport toward the core.
// Optional: define I2C_SEQ_TIMEOUT_EN to abandon a byte phase after TIMEOUT_POLLS status reads (status 10).
module i2c_apb_sequencer #(
    parameter logic [15:0] PRESCALE      = 16'd99,
    parameter logic [15:0] TIMEOUT_POLLS = 16'd4095
) (
    input  logic       PCLK,
    input  logic       PRESETn,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic       req_write,
    input  logic [6:0] req_dev,
    input  logic [7:0] req_reg,
    input  logic [7:0] req_wdata,
    output logic       rsp_valid,
    output logic [7:0] rsp_rdata,
    output logic [1:0] rsp_status,
    output logic       busy,
    i2c_apb_sequencer_if.master apb
);
    typedef enum logic [2:0] {IDLE, INIT, APB_SETUP, APB_ACCESS, POLL, NEXT, STOP, DONE} state_t;
    typedef enum logic [2:0] {OP_PLO, OP_PHI, OP_CTR, OP_TXR, OP_CR, OP_SR, OP_RXR} op_t;
    state_t     state, state_n;
    op_t        op, op_n;
    logic [1:0] ph, ph_n, status_q, status_n;
    logic       stop_q, stop_n, wr_q, wr_n, tip_q, tip_n, ack_q, ack_n;
    logic [6:0] dev_q, dev_n;
    logic [7:0] reg_q, reg_n, wd_q, wd_n, rdata_q, rdata_n;
    logic [7:0] addr, txr, cr, wdat;
    logic       sel, wop;
`ifdef I2C_SEQ_TIMEOUT_EN
    logic [15:0] polls_q, polls_n;
`endif
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state    <= INIT;
            op       <= OP_PLO;
            ph       <= 2'd0;
            status_q <= 2'b00;
            stop_q   <= 1'b0;
            wr_q     <= 1'b0;
            tip_q    <= 1'b0;
            ack_q    <= 1'b0;
            dev_q    <= 7'h00;
            reg_q    <= 8'h00;
            wd_q     <= 8'h00;
            rdata_q  <= 8'h00;
`ifdef I2C_SEQ_TIMEOUT_EN
            polls_q  <= 16'd0;
`endif
        end else begin
            state    <= state_n;
            op       <= op_n;
            ph       <= ph_n;
            status_q <= status_n;
            stop_q   <= stop_n;
            wr_q     <= wr_n;
            tip_q    <= tip_n;
            ack_q    <= ack_n;
            dev_q    <= dev_n;
            reg_q    <= reg_n;
            wd_q     <= wd_n;
            rdata_q  <= rdata_n;
`ifdef I2C_SEQ_TIMEOUT_EN
            polls_q  <= polls_n;
`endif
        end
    end
    always_comb begin
        state_n  = state;
        op_n     = op;
        ph_n     = ph;
        status_n = status_q;
        stop_n   = stop_q;
        wr_n     = wr_q;
        tip_n    = tip_q;
        ack_n    = ack_q;
        dev_n    = dev_q;
        reg_n    = reg_q;
        wd_n     = wd_q;
        rdata_n  = rdata_q;
`ifdef I2C_SEQ_TIMEOUT_EN
        polls_n  = polls_q;
`endif
        case (state)
            IDLE: if (req_valid) begin
                state_n  = APB_SETUP;
                op_n     = OP_TXR;
                ph_n     = 2'd0;
                stop_n   = 1'b0;
                status_n = 2'b00;
                wr_n     = req_write;
                dev_n    = req_dev;
                reg_n    = req_reg;
                wd_n     = req_wdata;
            end
            INIT:      state_n = APB_SETUP;
            APB_SETUP: state_n = APB_ACCESS;
            APB_ACCESS: if (apb.PREADY) begin
                state_n = (op == OP_SR) ? POLL : NEXT;
                if (op == OP_SR) begin
                    tip_n = apb.PRDATA[1];
                    ack_n = apb.PRDATA[7];
`ifdef I2C_SEQ_TIMEOUT_EN
                    polls_n = polls_q + 16'd1;
`endif
                end
                if (op == OP_RXR) rdata_n = apb.PRDATA[7:0];
            end
            NEXT: begin
                state_n = APB_SETUP;
                case (op)
                    OP_PLO:  op_n = OP_PHI;
                    OP_PHI:  op_n = OP_CTR;
                    OP_CTR:  state_n = IDLE;
                    OP_TXR:  op_n = OP_CR;
                    OP_CR: begin
                        op_n = OP_SR;
`ifdef I2C_SEQ_TIMEOUT_EN
                        polls_n = 16'd0;
                        // a timed-out phase sends STOP without waiting for the stuck core
                        if (stop_q && status_q == 2'b10) state_n = DONE;
`endif
                    end
                    default: state_n = DONE;
                endcase
            end
            POLL: begin
                if (tip_q) begin
                    state_n = APB_SETUP;
`ifdef I2C_SEQ_TIMEOUT_EN
                    if (polls_q == TIMEOUT_POLLS) begin
                        state_n  = STOP;
                        status_n = 2'b10;
                    end
`endif
                end else if (stop_q) begin
                    state_n = DONE;
                // the final read phase always NACKs by design, so RxACK is ignored there
                end else if (ack_q && !(!wr_q && ph == 2'd3)) begin
                    state_n  = STOP;
                    status_n = 2'b01;
                end else if (wr_q && ph == 2'd2) begin
                    state_n = DONE;
                end else if (ph == 2'd3) begin
                    op_n    = OP_RXR;
                    state_n = APB_SETUP;
                end else begin
                    ph_n    = ph + 2'd1;
                    op_n    = (ph == 2'd2) ? OP_CR : OP_TXR;
                    state_n = APB_SETUP;
                end
            end
            STOP: begin
                stop_n  = 1'b1;
                op_n    = OP_CR;
                state_n = APB_SETUP;
            end
            DONE: state_n = IDLE;
            default: state_n = INIT;
        endcase
    end
    always_comb begin
        addr = (op == OP_PLO) ? 8'h00 : (op == OP_PHI) ? 8'h04 : (op == OP_CTR) ? 8'h08 :
               (op == OP_TXR || op == OP_RXR) ? 8'h0C : 8'h10;
        txr  = (ph == 2'd0) ? {dev_q, 1'b0} : (ph == 2'd1) ? reg_q : wr_q ? wd_q : {dev_q, 1'b1};
        cr   = stop_q ? 8'h40 : (ph == 2'd0) ? 8'h90 : (ph == 2'd1) ? 8'h10 :
               (ph == 2'd2) ? (wr_q ? 8'h50 : 8'h90) : 8'h68;
        wdat = (op == OP_PLO) ? PRESCALE[7:0] : (op == OP_PHI) ? PRESCALE[15:8] :
               (op == OP_CTR) ? 8'h80 : (op == OP_TXR) ? txr : (op == OP_CR) ? cr : 8'h00;
        sel  = (state == APB_SETUP) || (state == APB_ACCESS);
        wop  = (op != OP_SR) && (op != OP_RXR);
        apb.PSEL    = sel;
        apb.PENABLE = (state == APB_ACCESS);
        apb.PWRITE  = sel && wop;
        apb.PADDR   = sel ? {24'h0, addr} : 32'h0;
        apb.PWDATA  = (sel && wop) ? {24'h0, wdat} : 32'h0;
        req_ready   = (state == IDLE);
        busy        = (state != IDLE);
        rsp_valid   = (state == DONE);
        rsp_rdata   = rdata_q;
        rsp_status  = status_q;
    end
endmodule

// File: tb/tb_i2c_apb_sequencer.sv
// tb_i2c_apb_sequencer: randomized bench with a transfer-list model of the sequencer and an APB slave fed from it.
module tb_i2c_apb_sequencer;
    typedef struct packed {logic w; logic [7:0] a; logic [7:0] d;} xfer_t;
    typedef struct packed {logic [1:0] st; logic [7:0] rd;} rsp_t;

    logic       PCLK = 1'b0;
    logic       PRESETn = 1'b1;
    logic       req_valid, req_ready, req_write, rsp_valid, busy;
    logic [6:0] req_dev;
    logic [7:0] req_reg, req_wdata, rsp_rdata;
    logic [1:0] rsp_status;

    i2c_apb_sequencer_if apb();

    i2c_apb_sequencer #(.PRESCALE(16'd99), .TIMEOUT_POLLS(16'd4)) dut (
        .PCLK(PCLK), .PRESETn(PRESETn),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_dev(req_dev), .req_reg(req_reg), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_status(rsp_status),
        .busy(busy), .apb(apb)
    );

    always #5 PCLK = ~PCLK;

    xfer_t      exp_q[$];
    rsp_t       rsp_q[$];
    logic [7:0] m_rdata = 8'h00;
    logic [7:0] last_rd = 8'h00;
    int         n_chk = 0;
    int         n_fail = 0;
    int         fixed_wait = -1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp_v);
        n_chk++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp_v, $time);
        end
    endtask

    // ---------------- reference model: expected APB transfer list and responses ----------------
    task automatic m_push(input logic w, input logic [7:0] a, input logic [7:0] d);
        exp_q.push_back({w, a, d});
    endtask

    task automatic m_poll(input int n, input logic ack);
        repeat (n) m_push(1'b0, 8'h10, 8'($urandom) | 8'h02);
        m_push(1'b0, 8'h10, (8'($urandom) & 8'h7D) | {ack, 7'b0});
    endtask

    task automatic m_init();
        m_push(1'b1, 8'h00, 8'h63);
        m_push(1'b1, 8'h04, 8'h00);
        m_push(1'b1, 8'h08, 8'h80);
    endtask

    task automatic m_txn(input logic wr, input logic [6:0] dev, input logic [7:0] rg, input logic [7:0] wd,
                         input logic [7:0] rx, input int nack, input logic [7:0] bz);
        logic [7:0] txr [3];
        logic [7:0] cr [3];
        txr[0] = {dev, 1'b0};
        txr[1] = rg;
        txr[2] = wr ? wd : {dev, 1'b1};
        cr[0] = 8'h90;
        cr[1] = 8'h10;
        cr[2] = wr ? 8'h50 : 8'h90;
        for (int i = 0; i < 3; i++) begin
            m_push(1'b1, 8'h0C, txr[i]);
            m_push(1'b1, 8'h10, cr[i]);
            m_poll(int'(bz[2*i +: 2]), nack == i);
            if (nack == i) begin
                m_push(1'b1, 8'h10, 8'h40);
                m_poll(int'(bz[7:6]), 1'($urandom));
                rsp_q.push_back({2'b01, m_rdata});
                return;
            end
        end
        if (!wr) begin
            m_push(1'b1, 8'h10, 8'h68);
            m_poll(int'(bz[7:6]), 1'($urandom));
            m_push(1'b0, 8'h0C, rx);
            m_rdata = rx;
        end
        rsp_q.push_back({2'b00, m_rdata});
    endtask

    task automatic pin(input string nm, input int i, input logic [16:0] exp_v);
        chk(nm, exp_q[i], exp_v);
    endtask

    // ---------------- APB slave: wait states and read data taken from the model list ----------------
    int waits = 0;
    initial begin
        apb.PREADY = 1'b0;
        apb.PRDATA = 32'h0;
        forever begin
            @(posedge PCLK);
            #1;
            if (apb.PSEL && !apb.PENABLE) waits = (fixed_wait >= 0) ? fixed_wait : int'($urandom_range(0, 2));
            apb.PREADY = 1'b0;
            if (apb.PSEL && apb.PENABLE) begin
                if (waits == 0) apb.PREADY = 1'b1;
                else waits--;
            end
            apb.PRDATA = {24'($urandom), (exp_q.size() > 0 && !exp_q[0].w) ? exp_q[0].d : 8'h00};
        end
    end

    // ---------------- compare process ----------------
    logic        prev_pend = 1'b0, prev_done = 1'b0, prev_w = 1'b0;
    logic [31:0] prev_a = 32'h0, prev_d = 32'h0;
    xfer_t       e;
    rsp_t        r;
    always @(negedge PCLK) begin
        if (!PRESETn) begin
            chk("rst_hold", {apb.PSEL, busy, req_ready, rsp_valid}, 4'b0100);
            prev_pend = 1'b0;
            prev_done = 1'b0;
        end else begin
            chk("ready_vs_busy", req_ready, !busy);
            if (prev_pend) begin
                chk("apb_hold_ctl", {apb.PSEL, apb.PENABLE, apb.PWRITE}, {2'b11, prev_w});
                chk("apb_hold_addr", apb.PADDR, prev_a);
                chk("apb_hold_data", apb.PWDATA, prev_d);
            end else if (prev_done) begin
                chk("apb_release_ctl", {apb.PSEL, apb.PENABLE, apb.PWRITE}, 3'b000);
                chk("apb_release_bus", {apb.PADDR, apb.PWDATA}, 64'h0);
            end else if (apb.PSEL) begin
                chk("apb_setup_first", apb.PENABLE, 1'b0);
            end
            if (apb.PSEL && apb.PENABLE && apb.PREADY) begin
                if (exp_q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL xfer_extra: got w=%0b addr=%0h data=%0h expected no transfer", apb.PWRITE, apb.PADDR, apb.PWDATA);
                end else begin
                    e = exp_q.pop_front();
                    chk("xfer_ctl", {apb.PWRITE, apb.PADDR}, {e.w, 24'h0, e.a});
                    if (e.w) chk("xfer_wdata", apb.PWDATA, {24'h0, e.d});
                end
                prev_done = 1'b1;
                prev_pend = 1'b0;
            end else begin
                prev_done = 1'b0;
                prev_pend = apb.PSEL;
                prev_w = apb.PWRITE;
                prev_a = apb.PADDR;
                prev_d = apb.PWDATA;
            end
            if (rsp_valid) begin
                if (rsp_q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL rsp_extra: got status=%0h rdata=%0h expected no response", rsp_status, rsp_rdata);
                end else begin
                    r = rsp_q.pop_front();
                    chk("rsp_status", rsp_status, r.st);
                    chk("rsp_rdata", rsp_rdata, r.rd);
                    chk("rsp_after_all_xfers", exp_q.size(), 0);
                    last_rd = r.rd;
                end
            end else if (req_ready) begin
                chk("rdata_hold", rsp_rdata, last_rd);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic wait_idle();
        int i;
        i = 0;
        while (i < 3000 && !(req_ready && exp_q.size() == 0 && rsp_q.size() == 0)) begin
            req_valid = busy ? 1'($urandom) : 1'b0;
            req_write = 1'($urandom);
            req_dev = 7'($urandom);
            req_reg = 8'($urandom);
            req_wdata = 8'($urandom);
            @(posedge PCLK);
            #1;
            i++;
        end
        req_valid = 1'b0;
        chk("idle_reached", {req_ready, exp_q.size() == 0, rsp_q.size() == 0}, 3'b111);
    endtask

    task automatic do_req(input logic wr, input logic [6:0] dev, input logic [7:0] rg, input logic [7:0] wd);
        for (int i = 0; i < 200 && !req_ready; i++) begin
            @(posedge PCLK);
            #1;
        end
        req_valid = 1'b1;
        req_write = wr;
        req_dev = dev;
        req_reg = rg;
        req_wdata = wd;
        @(posedge PCLK);
        #1;
        req_valid = 1'b0;
        req_write = 1'($urandom);
        req_dev = 7'($urandom);
        req_reg = 8'($urandom);
        req_wdata = 8'($urandom);
        chk("busy_rise", {busy, req_ready}, 2'b10);
    endtask

    task automatic do_reset(input bit pins);
        PRESETn = 1'b0;
        exp_q.delete();
        rsp_q.delete();
        m_rdata = 8'h00;
        last_rd = 8'h00;
        #1;
        chk("rst_apb_ctl", {apb.PSEL, apb.PENABLE, apb.PWRITE}, 3'b000);
        chk("rst_apb_bus", {apb.PADDR, apb.PWDATA}, 64'h0);
        chk("rst_req", {req_ready, busy, rsp_valid}, 3'b010);
        chk("rst_rsp", {rsp_rdata, rsp_status}, 10'h0);
        repeat (2) @(posedge PCLK);
        m_init();
        if (pins) begin
            pin("pin_init_lo", 0, {1'b1, 8'h00, 8'h63});
            pin("pin_init_hi", 1, {1'b1, 8'h04, 8'h00});
            pin("pin_init_ctr", 2, {1'b1, 8'h08, 8'h80});
        end
        #3 PRESETn = 1'b1;
        wait_idle();
    endtask

    initial begin
        req_valid = 1'b0;
        req_write = 1'b0;
        req_dev = 7'h00;
        req_reg = 8'h00;
        req_wdata = 8'h00;
        #2;
        do_reset(1'b1);

        m_txn(1'b1, 7'h50, 8'h12, 8'hA5, 8'h00, -1, 8'h00);
        pin("pin_wr_txr0", 0, {1'b1, 8'h0C, 8'hA0});
        pin("pin_wr_cr0", 1, {1'b1, 8'h10, 8'h90});
        pin("pin_wr_txr1", 3, {1'b1, 8'h0C, 8'h12});
        pin("pin_wr_cr1", 4, {1'b1, 8'h10, 8'h10});
        pin("pin_wr_txr2", 6, {1'b1, 8'h0C, 8'hA5});
        pin("pin_wr_cr2", 7, {1'b1, 8'h10, 8'h50});
        do_req(1'b1, 7'h50, 8'h12, 8'hA5);
        wait_idle();
        chk("pin_wr_status", rsp_status, 2'b00);

        m_txn(1'b0, 7'h50, 8'h03, 8'h00, 8'h3C, -1, 8'h00);
        pin("pin_rd_txr0", 0, {1'b1, 8'h0C, 8'hA0});
        pin("pin_rd_txr1", 3, {1'b1, 8'h0C, 8'h03});
        pin("pin_rd_txr2", 6, {1'b1, 8'h0C, 8'hA1});
        pin("pin_rd_cr_read", 9, {1'b1, 8'h10, 8'h68});
        pin("pin_rd_rxr", 11, {1'b0, 8'h0C, 8'h3C});
        do_req(1'b0, 7'h50, 8'h03, 8'h00);
        wait_idle();
        chk("pin_rd_result", {rsp_rdata, rsp_status}, {8'h3C, 2'b00});

        m_txn(1'b1, 7'h50, 8'h12, 8'hA5, 8'h00, 0, 8'h00);
        chk("pin_nack_len", exp_q.size(), 5);
        pin("pin_nack_stop", 3, {1'b1, 8'h10, 8'h40});
        do_req(1'b1, 7'h50, 8'h12, 8'hA5);
        wait_idle();
        chk("pin_nack_result", {rsp_rdata, rsp_status}, {8'h3C, 2'b01});

        fixed_wait = 3;
        m_txn(1'b1, 7'h21, 8'h44, 8'h99, 8'h00, -1, 8'h03);
        do_req(1'b1, 7'h21, 8'h44, 8'h99);
        for (int i = 0; i < 500 && !(apb.PSEL && apb.PENABLE && !apb.PWRITE && apb.PADDR == 32'h10); i++) begin
            @(posedge PCLK);
            #1;
        end
        chk("poll_seen", {apb.PSEL, apb.PENABLE, apb.PWRITE, apb.PADDR}, {3'b110, 32'h10});
        #3;
        do_reset(1'b0);
        m_txn(1'b0, 7'h3A, 8'h7E, 8'h00, 8'hC3, -1, 8'h1B);
        do_req(1'b0, 7'h3A, 8'h7E, 8'h00);
        wait_idle();
        fixed_wait = -1;

`ifdef I2C_SEQ_TIMEOUT_EN
        m_push(1'b1, 8'h0C, 8'hA0);
        m_push(1'b1, 8'h10, 8'h90);
        repeat (4) m_push(1'b0, 8'h10, 8'($urandom) | 8'h02);
        m_push(1'b1, 8'h10, 8'h40);
        rsp_q.push_back({2'b10, m_rdata});
        do_req(1'b1, 7'h50, 8'h12, 8'hA5);
        wait_idle();
        chk("pin_timeout_status", rsp_status, 2'b10);
`endif

        for (int k = 0; k < 30; k++) begin
            logic       wr;
            logic [6:0] dev;
            logic [7:0] rg, wd, rx, bz;
            int         nk;
            wr = 1'($urandom);
            dev = 7'($urandom);
            rg = 8'($urandom);
            wd = 8'($urandom);
            rx = 8'($urandom);
            bz = 8'($urandom);
            nk = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 2)) : -1;
            m_txn(wr, dev, rg, wd, rx, nk, bz);
            do_req(wr, dev, rg, wd);
            wait_idle();
        end

        chk("queues_drained", exp_q.size() + rsp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/i2c_apb_sequencer.md
I2C_APB_SEQUENCER -- requirements
Module: i2c_apb_sequencer

Interface
REQ-001 SHALL have parameter PRESCALE, default 16'd99, meaning I2C prescale value written to the core at init.
REQ-002 SHALL have parameter TIMEOUT_POLLS, default 16'd4095, meaning the maximum number of status polls per byte phase (used only with I2C_SEQ_TIMEOUT_EN).
REQ-003 SHALL have ports: PCLK  in  1  clock; all logic on its rising edge.
REQ-004 SHALL have ports: PRESETn  in  1  reset; one clock, asynchronous, active-low.
REQ-005 SHALL have ports: req_valid in 1 request strobe; req_ready out 1 sequencer accepts; req_write in 1 write (1) or read (0); req_dev in 7 I2C slave address; req_reg in 8 slave register index; req_wdata in 8 write byte.
REQ-006 SHALL have ports: rsp_valid out 1 one-cycle completion pulse; rsp_rdata out 8 read byte; rsp_status out 2 completion code (00 ok, 01 NACK, 10 timeout); busy out 1 init or transaction in progress.
REQ-007 SHALL have ports: PSEL out 1; PENABLE out 1; PWRITE out 1; PADDR out 32; PWDATA out 32; PRDATA in 32; PREADY in 1. These form the APB master toward the I2C peripheral.

Function
REQ-008 SHALL use these core register offsets: PRERlo 0x00, PRERhi 0x04, CTR 0x08, TXR/RXR 0x0C, CR/SR 0x10. PADDR[31:8] SHALL be 0, and PWDATA[31:8] SHALL be 0.
REQ-009 SHALL perform each APB transfer as a SETUP cycle (PSEL=1, PENABLE=0) followed by ACCESS cycles (PSEL=1, PENABLE=1) held until PREADY=1. PSEL, PENABLE, PADDR, PWRITE and PWDATA SHALL stay stable through ACCESS, and SHALL return to 0 in the cycle after completion.
REQ-010 SHALL, after reset, run INIT: write PRERlo=PRESCALE[7:0], then PRERhi=PRESCALE[15:8], then CTR=0x80. req_ready SHALL stay 0 and busy SHALL stay 1 until INIT completes.
REQ-011 SHALL assert req_ready=1 only in IDLE. A request SHALL be accepted on the cycle where req_valid=1 and req_ready=1; req_* fields SHALL be captured at that edge, and busy SHALL rise the next cycle.
REQ-012 SHALL run each byte phase as: write TXR or CR, then repeatedly read SR until SR[1] (TIP)=0. The completed SR read SHALL sample SR[7] (RxACK).
REQ-013 SHALL run a write transaction as three phases:
- TXR={dev,0}, CR=0x90
- TXR=reg, CR=0x10
- TXR=wdata, CR=0x50 (write plus STOP)
REQ-014 SHALL run a read transaction as follows:
- TXR={dev,0}, CR=0x90
- TXR=reg, CR=0x10
- TXR={dev,1}, CR=0x90 (repeated START)
- CR=0x68 (read, NACK, STOP), poll
- read RXR at 0x0C into rsp_rdata
REQ-015 SHALL treat RxACK=1 on any address or data-write phase as NACK: abort the remaining phases, write CR=0x40 (STOP), poll TIP=0, then complete with status 01.
REQ-016 SHALL complete by pulsing rsp_valid for exactly one cycle with rsp_status, then return to IDLE. rsp_rdata SHALL hold its value until the next read completion; it is 0x00 after reset.
REQ-017 SHALL ignore req_valid while busy. No request SHALL be queued.
REQ-018 SHALL have FSM states IDLE, INIT, APB_SETUP, APB_ACCESS, POLL, NEXT, STOP, DONE. A phase counter SHALL select the register, data, and next phase.

Reset
REQ-019 SHALL, on PRESETn=0 and independent of PCLK, force these outputs to 0: PSEL, PENABLE, PWRITE, PADDR, PWDATA, req_ready, rsp_valid, rsp_rdata, rsp_status. busy SHALL go to 1, and the FSM SHALL go to INIT.
REQ-020 SHALL abandon any in-flight transaction when reset asserts mid-operation, with no rsp_valid. INIT SHALL rerun after reset release.

Configuration
REQ-021 SHALL, when I2C_SEQ_TIMEOUT_EN is defined, count SR reads per phase. If TIP is still 1 after TIMEOUT_POLLS reads, the sequencer SHALL write CR=0x40 without polling and complete with status 10.
REQ-022 SHALL, when I2C_SEQ_TIMEOUT_EN is undefined, poll indefinitely, contain no timeout counter, and never produce status 10.

Verification
REQ-023 SHALL cover reset then INIT with PRESCALE=99: bench sees APB writes (0x00,0x63), (0x04,0x00), (0x08,0x80), then req_ready=1.
REQ-024 SHALL cover a write with dev=0x50, reg=0x12, wdata=0xA5 and slave ACK on every phase: TXR writes 0xA0, 0x12, 0xA5; CR writes 0x90, 0x10, 0x50; result rsp_status=00.
REQ-025 SHALL cover a read with dev=0x50, reg=0x03 and RXR model=0x3C: TXR writes 0xA0, 0x03, 0xA1; final CR=0x68; result rsp_rdata=0x3C, status 00.
REQ-026 SHALL cover a NACK on the first address phase (SR=0x80): bench sees CR=0x40 with no further TXR writes, and rsp_status=01.
REQ-027 SHALL cover PREADY held 0 for 3 cycles per access and PRESETn asserted mid-poll: APB signals are held stable while PREADY=0; reset clears PSEL immediately, no rsp_valid occurs, and INIT reruns.
REQ-028 SHALL, with I2C_SEQ_TIMEOUT_EN and TIMEOUT_POLLS=4 and TIP stuck at 1, complete with exactly 4 SR reads, then CR=0x40, then rsp_status=10.
